alu_stream_path: RTL and testbench

//   Parametrised successor of the single-word control path. Buffers operation tokens {op,a,b}
//   in an internal FIFO and executes them one at a time on a multi-cycle ALU (ADD/SUB 1 cycle,
//   MUL shift-add, DIV restoring). Results and flags leave on a valid/ready output port.

---
 rtl/alu_stream_path.sv | 203 ++++++++++++++++++++
 tb/tb_alu_stream_path.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_stream_path.sv
// alu_stream_path: FIFO-buffered {op,a,b} token stream feeding a multi-cycle ADD/SUB/MUL/DIV unit.
// Each result and its flags are held on a valid/ready port until the consumer takes it.
module alu_stream_path #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_op,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_lo,
  output logic [W-1:0] out_hi,
  output logic         cout,
  output logic         overflow,
  output logic         div_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(W);
  localparam int unsigned TW = 2 + 2 * W;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t         r_state;
  logic [TW-1:0]  r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PW:0]    r_count;
  logic [PW:0]    w_count_nxt;
  logic           w_push, w_pop;
  logic [TW-1:0]  w_head;
  logic [1:0]     w_head_op;

  logic [1:0]     r_op;
  logic [W-1:0]   r_a, r_b, r_hi, r_lo;
  logic [CW-1:0]  r_cnt;

  logic [W:0]     w_sum, w_diff, w_madd, w_dshift;
  logic [W-1:0]   w_mhi, w_mlo, w_dsub, w_dhi, w_dlo;
  logic           w_dge, w_last;

  assign w_push    = in_valid && in_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_op = w_head[TW-1:TW-2];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (PW+1)'(1);
      2'b01:   w_count_nxt = r_count - (PW+1)'(1);
      default: ;
    endcase
  end

  // Storage is write-only on push; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_op, in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count  <= w_count_nxt;
      in_ready <= (w_count_nxt != (PW+1)'(DEPTH));
    end
  end

  // One step of the shift-add multiplier and restoring divider; r_hi/r_lo hold the working pair.
  always_comb begin
    w_sum    = {1'b0, r_a} + {1'b0, r_b};
    w_diff   = {1'b0, r_a} - {1'b0, r_b};
    w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : (W+1)'(0));
    w_mhi    = w_madd[W:1];
    w_mlo    = {w_madd[0], r_lo[W-1:1]};
    w_dshift = {r_hi, r_lo[W-1]};
    w_dge    = (w_dshift >= {1'b0, r_b});
    w_dsub   = W'(w_dshift - {1'b0, r_b});
    w_dhi    = w_dge ? w_dsub : w_dshift[W-1:0];
    w_dlo    = {r_lo[W-2:0], w_dge};
    w_last   = (r_cnt == CW'(W - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      out_lo    <= '0;
      out_hi    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op    <= w_head_op;
            r_a     <= w_head[2*W-1:W];
            r_b     <= w_head[W-1:0];
            r_hi    <= '0;
            r_lo    <= (w_head_op == OP_MUL) ? w_head[W-1:0] : w_head[2*W-1:W];
            r_cnt   <= '0;
            r_state <= S_EXEC;
            busy    <= 1'b1;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_ADD: begin
              out_lo    <= w_sum[W-1:0];
              out_hi    <= '0;
              cout      <= w_sum[W];
              overflow  <= (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
              div_zero  <= 1'b0;
              out_valid <= 1'b1;
              r_state   <= S_DONE;
            end
            OP_SUB: begin
              out_lo    <= w_diff[W-1:0];
              out_hi    <= '0;
              cout      <= w_diff[W];
              overflow  <= (r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1]);
              div_zero  <= 1'b0;
              out_valid <= 1'b1;
              r_state   <= S_DONE;
            end
            OP_MUL: begin
              r_hi  <= w_mhi;
              r_lo  <= w_mlo;
              r_cnt <= r_cnt + CW'(1);
              if (w_last) begin
                out_lo    <= w_mlo;
                out_hi    <= w_mhi;
                cout      <= 1'b0;
                overflow  <= (w_mhi != '0);
                div_zero  <= 1'b0;
                out_valid <= 1'b1;
                r_state   <= S_DONE;
              end
            end
            default: begin
              if (r_b == '0) begin
                out_lo    <= '1;
                out_hi    <= r_a;
                cout      <= 1'b0;
                overflow  <= 1'b0;
                div_zero  <= 1'b1;
                out_valid <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_hi  <= w_dhi;
                r_lo  <= w_dlo;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                  out_lo    <= w_dlo;
                  out_hi    <= w_dhi;
                  cout      <= 1'b0;
                  overflow  <= 1'b0;
                  div_zero  <= 1'b0;
                  out_valid <= 1'b1;
                  r_state   <= S_DONE;
                end
              end
            end
          endcase
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_stream_path.sv
// Scoreboard bench for alu_stream_path: directed tokens push expectations, a monitor
// pops and compares on every output handshake.
module tb_alu_stream_path;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [1:0]   in_op = 2'b00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_lo, out_hi;
  logic         cout, overflow, div_zero, out_valid, busy;
  logic         out_ready = 1'b0;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alu_stream_path #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_valid(in_valid), .in_ready(in_ready), .out_lo(out_lo), .out_hi(out_hi),
    .cout(cout), .overflow(overflow), .div_zero(div_zero), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic exp_t mk(input logic [7:0] lo, input logic [7:0] hi,
                              input logic c, input logic v, input logic z);
    exp_t e;
    e.lo = lo; e.hi = hi; e.c = c; e.v = v; e.z = z;
    return e;
  endfunction

  // Monitor: every accepted result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(out_lo), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_lo",   32'(out_lo),   32'(e.lo));
        check("out_hi",   32'(out_hi),   32'(e.hi));
        check("cout",     32'(cout),     32'(e.c));
        check("overflow", 32'(overflow), 32'(e.v));
        check("div_zero", 32'(div_zero), 32'(e.z));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic track, input exp_t e);
    int k = 0;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && k < 300) begin
      @(posedge clk); #1; k++;
    end
    if (in_ready) begin
      if (track) sb.push_back(e);
      @(posedge clk); #1;
    end else begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic lat_test(input string name, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input exp_t e, input int lat);
    send(op, a, b, 1'b1, e);
    repeat (lat - 1) @(posedge clk);
    #1;
    check({name, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out",       {16'(out_hi), 16'(out_lo)}, 32'd0);
    check("rst_flags",     32'({cout, overflow, div_zero}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    lat_test("add_carry", 2'b00, 8'd200, 8'd100, mk(8'h2C, 8'h00, 1, 0, 0), 2);
    lat_test("add_ovf",   2'b00, 8'd100, 8'd100, mk(8'hC8, 8'h00, 0, 1, 0), 2);
    lat_test("sub_borrow", 2'b01, 8'd5, 8'd7,    mk(8'hFE, 8'h00, 1, 0, 0), 2);
    lat_test("sub_ovf",   2'b01, 8'h80, 8'h01,   mk(8'h7F, 8'h00, 0, 1, 0), 2);
    lat_test("mul_ff",    2'b10, 8'd15, 8'd17,   mk(8'hFF, 8'h00, 0, 0, 0), 9);
    lat_test("mul_ovf",   2'b10, 8'd16, 8'd16,   mk(8'h00, 8'h01, 0, 1, 0), 9);
    lat_test("div",       2'b11, 8'd100, 8'd7,   mk(8'd14, 8'd2,  0, 0, 0), 9);
    lat_test("div_zero",  2'b11, 8'd9, 8'd0,     mk(8'hFF, 8'h09, 0, 0, 1), 2);

    // Backpressure: one token in EXEC plus four in the FIFO, sixth must stall.
    send(2'b00, 8'd1,   8'd2, 1'b1, mk(8'd3,  8'd0, 0, 0, 0));
    send(2'b01, 8'd10,  8'd3, 1'b1, mk(8'd7,  8'd0, 0, 0, 0));
    send(2'b10, 8'd3,   8'd4, 1'b1, mk(8'd12, 8'd0, 0, 0, 0));
    send(2'b11, 8'd50,  8'd6, 1'b1, mk(8'd8,  8'd2, 0, 0, 0));
    send(2'b00, 8'hFF,  8'd1, 1'b1, mk(8'h00, 8'd0, 1, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    in_op = 2'b01; in_a = 8'd0; in_b = 8'd1; in_valid = 1'b1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_busy",     32'(busy),     32'd1);
    fork
      send(2'b01, 8'd0, 8'd1, 1'b1, mk(8'hFF, 8'd0, 1, 0, 0));
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("idle_after_drain", 32'({out_valid, busy}), 32'd0);

    // Reset during MUL EXEC discards the op; nothing may surface afterwards.
    send(2'b10, 8'd15, 8'd17, 1'b0, mk(8'hFF, 8'h00, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    check("mul_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_ghost_valid", 32'(out_valid), 32'd0);
    check("no_ghost_busy",  32'(busy),      32'd0);
    out_ready = 1'b0;
    send(2'b00, 8'h7F, 8'h01, 1'b1, mk(8'h80, 8'h00, 0, 1, 0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
